// File: rtl/ir_frame_receiver.sv
// Pulse-distance (NEC-style) IR frame decoder with timed phases,
// leader validation, timeout abort and a valid/ack frame handoff.
module ir_frame_receiver #(
    parameter int unsigned BITS       = 32,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned LEADER_MIN = 9000,
    parameter int unsigned SPACE_MIN  = 4000,
    parameter int unsigned BIT_THRESH = 1100,
    parameter int unsigned TIMEOUT    = 20000,
    localparam int         CW         = $clog2(BITS + 1),
    localparam int         TW         = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ir_in,
    input  logic            data_ack,
    output logic [BITS-1:0] data_out,
    output logic            data_valid,
    output logic            overrun,
    output logic            frame_err,
    output logic            busy,
    output logic [CW-1:0]   bit_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE
    } state_t;

    state_t          state;
    logic            s1;
    logic            ir_s;
    logic            ir_d;
    logic [TW-1:0]   timer;
    logic [BITS-1:0] sr;
    logic            done;

    logic            fall;
    logic            rise;
    logic            timeout;
    logic            lead_ok;
    logic            space_ok;
    logic            bit_val;
    logic            last_bit;

    // Edges of the synchronised line and phase-length decisions.
    always_comb begin
        fall     = ir_d & ~ir_s;
        rise     = ~ir_d & ir_s;
        timeout  = (timer == TW'(TIMEOUT));
        lead_ok  = (32'(timer) >= LEADER_MIN);
        space_ok = (32'(timer) >= SPACE_MIN);
        bit_val  = (32'(timer) > BIT_THRESH);
        last_bit = (bit_cnt == CW'(BITS - 1));
    end

    // Insert one decoded bit at the end that matches the bit order.
    function automatic logic [BITS-1:0] shift_in(
        input logic [BITS-1:0] v,
        input logic            b
    );
        logic [BITS-1:0] r;
        if (LSB_FIRST) begin
            r         = v >> 1;
            r[BITS-1] = b;
        end else begin
            r    = v << 1;
            r[0] = b;
        end
        return r;
    endfunction

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b1;
            ir_s <= 1'b1;
            ir_d <= 1'b1;
        end else begin
            s1   <= ir_in;
            ir_s <= s1;
            ir_d <= ir_s;
        end
    end

    // Phase timer: restarts on every edge, saturates at the abort limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (fall || rise) begin
            timer <= '0;
        end else if (!timeout) begin
            timer <= timer + TW'(1);
        end
    end

    // Frame state machine: leader check, bit capture, timeout abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            done      <= 1'b0;
            if (state != IDLE && timeout) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                bit_cnt   <= '0;
                sr        <= '0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (fall) begin
                            state <= LEAD_MARK;
                            busy  <= 1'b1;
                        end
                    end
                    LEAD_MARK: begin
                        if (rise) begin
                            if (lead_ok) begin
                                state <= LEAD_SPACE;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    LEAD_SPACE: begin
                        if (fall) begin
                            if (space_ok) begin
                                state   <= BIT_MARK;
                                bit_cnt <= '0;
                                sr      <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    BIT_MARK: begin
                        if (rise) begin
                            state <= BIT_SPACE;
                        end
                    end
                    BIT_SPACE: begin
                        if (fall) begin
                            sr <= shift_in(sr, bit_val);
                            if (last_bit) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                bit_cnt <= '0;
                                done    <= 1'b1;
                            end else begin
                                state   <= BIT_MARK;
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Frame handoff: load on completion, flag overrun, clear on ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!data_valid || data_ack) begin
                data_out   <= sr;
                data_valid <= 1'b1;
                if (data_ack) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ir_frame_receiver.sv
// Randomised frame-level bench for ir_frame_receiver against a
// transaction-level model of the decoded data and handshake flags.
module tb_ir_frame_receiver;

    localparam int BITS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ir_in = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;
    logic [3:0] bit_cnt;

    int checks = 0;
    int failures = 0;
    int errcnt = 0;
    int cyc = 0;
    int err_cyc = 0;

    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;

    ir_frame_receiver #(
        .BITS       (BITS),
        .LSB_FIRST  (1'b1),
        .LEADER_MIN (16),
        .SPACE_MIN  (8),
        .BIT_THRESH (6),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_in      (ir_in),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) begin
            errcnt  <= errcnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        ir_in = lvl;
        tick(n);
    endtask

    task automatic send_head(input logic [7:0] d, input int n,
                             input bit rnd);
        hold(1'b0, rnd ? int'($urandom_range(18, 30)) : 20);
        hold(1'b1, rnd ? int'($urandom_range(10, 20)) : 10);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, rnd ? int'($urandom_range(2, 8)) : 4);
            if (d[i])
                hold(1'b1, rnd ? int'($urandom_range(9, 14)) : 10);
            else
                hold(1'b1, rnd ? int'($urandom_range(2, 5)) : 3);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit rnd);
        send_head(d, BITS, rnd);
        hold(1'b0, 4);
        hold(1'b1, 10);
    endtask

    task automatic m_complete(input logic [7:0] d, input bit ack);
        if (!m_valid || ack) begin
            m_data  = d;
            m_valid = 1'b1;
            if (ack) m_ovr = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic do_ack();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".data"}, 32'(data_out), 32'(m_data));
        chk({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        logic [7:0] d;
        int t0;

        tick(3);
        chk("rst.data", 32'(data_out), 0);
        chk("rst.valid", 32'(data_valid), 0);
        chk("rst.ovr", 32'(overrun), 0);
        chk("rst.err", 32'(frame_err), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.cnt", 32'(bit_cnt), 0);
        reset = 1'b1;
        tick(5);

        // basic frame with nominal timing
        send_head(8'h4D, BITS, 1'b0);
        chk("t1.busy_mid", 32'(busy), 1);
        hold(1'b0, 1);
        chk("t1.valid_early", 32'(data_valid), 0);
        hold(1'b0, 3);
        chk("t1.valid_3cyc", 32'(data_valid), 1);
        hold(1'b1, 10);
        m_complete(8'h4D, 1'b0);
        chk_model("t1");
        chk("t1.err", 32'(errcnt), 0);
        chk("t1.busy", 32'(busy), 0);
        do_ack();
        chk_model("t1.ack");

        // short leader mark is a glitch, not an error
        hold(1'b0, 10);
        hold(1'b1, 10);
        chk("t2.err", 32'(errcnt), 0);
        chk("t2.busy", 32'(busy), 0);
        d = 8'($urandom);
        send_frame(d, 1'b1);
        m_complete(d, 1'b0);
        chk_model("t2");

        // timeout after three bits with a frame still pending
        send_head(8'h05, 3, 1'b0);
        hold(1'b0, 4);
        chk("t3.cnt3", 32'(bit_cnt), 3);
        chk("t3.busy_mid", 32'(busy), 1);
        t0 = cyc;
        hold(1'b1, 70);
        chk("t3.err", 32'(errcnt), 1);
        chk("t3.err_early", 32'((err_cyc - t0) >= 60), 1);
        chk("t3.err_late", 32'((err_cyc - t0) <= 72), 1);
        chk("t3.cnt", 32'(bit_cnt), 0);
        chk("t3.busy", 32'(busy), 0);
        chk_model("t3");
        do_ack();

        // overrun: second frame while the first is unconsumed
        send_frame(8'h4D, 1'b0);
        m_complete(8'h4D, 1'b0);
        send_frame(8'hFF, 1'b0);
        m_complete(8'hFF, 1'b0);
        chk_model("t4");
        do_ack();
        chk_model("t4.ack");

        // ack coincident with completion replaces pending frame
        send_frame(8'h4D, 1'b0);
        m_complete(8'h4D, 1'b0);
        send_head(8'hFF, BITS, 1'b0);
        ir_in = 1'b0;
        tick(3);
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        tick(1);
        hold(1'b1, 10);
        m_complete(8'hFF, 1'b1);
        chk_model("t5");
        do_ack();

        // reset in the middle of a frame
        send_frame(8'hA5, 1'b1);
        m_complete(8'hA5, 1'b0);
        send_head(8'h3C, 5, 1'b1);
        reset = 1'b0;
        #1;
        chk("t6.data", 32'(data_out), 0);
        chk("t6.valid", 32'(data_valid), 0);
        chk("t6.ovr", 32'(overrun), 0);
        chk("t6.err", 32'(frame_err), 0);
        chk("t6.busy", 32'(busy), 0);
        chk("t6.cnt", 32'(bit_cnt), 0);
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        ir_in   = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(5);
        d = 8'($urandom);
        send_frame(d, 1'b1);
        m_complete(d, 1'b0);
        chk_model("t6.after");

        // random frames with random consumer behaviour
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) do_ack();
            d = 8'($urandom);
            send_frame(d, 1'b1);
            m_complete(d, 1'b0);
            chk_model("rnd");
        end
        chk("rnd.err", 32'(errcnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
